msrv32_lsu_ctrl: RTL and testbench
==================================

Name: msrv32_lsu_ctrl

Overview:
- Load/store control stage directly downstream of the instruction decoder.
- Consumes the decoder's memory request, size, signedness and misalignment results, plus the computed address (iadder) and rs2 data.
- Runs a wait-state data-bus handshake with timeout, and stalls the pipeline until the access completes.
- Returns an aligned, sign- or zero-extended load result to the write-back mux.

Parameters:
- TIMEOUT_CYCLES, 16, number of consecutive hready_in-low cycles in a bus state before the access is abandoned with bus_error_out.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- ms_riscv32_mp_clk_in  in  1  sole clock; all state changes on rising edge.
- ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-high.
- mem_wr_req_in  in  1  store request from decoder (already gated by trap/misalignment).
- mem_rd_req_in  in  1  load request (is_load & ~misaligned_load & ~trap).
- load_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word; applies to stores too.
- load_unsigned_in  in  1  1 = zero-extend load, 0 = sign-extend.
- iadder_in  in  32  effective byte address.
- rs2_in  in  32  store source data.
- trap_taken_in  in  1  blocks acceptance of new requests only.
- hready_in  in  1  bus ready/acknowledge.
- dmdata_in  in  32  bus read data, valid when hready_in=1.
- dmaddr_out  out  32  word-aligned address {iadder[31:2],2'b00}.
- dmdata_out  out  32  lane-replicated store data.
- dmwr_mask_out  out  4  byte-lane write strobes.
- dmwr_req_out  out  1  bus write request.
- dmrd_req_out  out  1  bus read request.
- stall_out  out  1  pipeline hold.
- load_data_out  out  32  aligned, extended load result.
- load_valid_out  out  1  one-cycle pulse when load_data_out is updated.
- bus_error_out  out  1  one-cycle pulse on timeout.

Behaviour:
- States: IDLE, WR, RD, DONE, ERR.
- Reset: state IDLE, wait counter 0. Every output is 0, including load_data_out.
- Reset mid-transaction: the access is abandoned; req outputs read 0 from the next cycle. No completion pulse.

IDLE:
- Request accepted when (mem_wr_req_in | mem_rd_req_in) & ~trap_taken_in.
- Write wins if both requests are high.
- On accept, register address, byte offset, size, unsigned flag, store data and mask. Next state is WR or RD.
- stall_out = accept (combinational), holding the instruction in place.

WR / RD:
- dmwr_req_out or dmrd_req_out = 1 while in the state; address, data and mask are stable throughout.
- stall_out = 1.
- hready_in=1: go to DONE. For RD, latch the extracted dmdata_in into load_data_out on that edge.
- hready_in=0: counter increments.
- Counter == TIMEOUT_CYCLES-1 with hready_in still 0: go to ERR.
- trap_taken_in is ignored; an issued transaction always completes or times out.

DONE:
- stall_out = 0; load_valid_out = 1 if the access was RD; all requests ignored.
- Next state IDLE, counter cleared.
- Minimum store/load occupancy is 3 cycles: accept, bus, DONE.

ERR:
- bus_error_out = 1, stall_out = 0, req outputs 0, load_data_out unchanged.
- Next state IDLE, counter cleared.

Store formatting:
- Byte: dmdata_out = {4{rs2[7:0]}}; mask = 0001 << addr[1:0].
- Half: dmdata_out = {2{rs2[15:0]}}; mask = 0011 when addr[1]=0, 1100 when addr[1]=1.
- Word or size 11: dmdata_out = rs2; mask = 1111.

Load extraction:
- Byte: dmdata_in[8*addr[1:0] +: 8].
- Half: dmdata_in[16*addr[1] +: 16].
- Word: full dmdata_in.
- Extension to 32 bits per the registered load_unsigned.
- load_data_out holds its value until the next successful load.

Decomposition:
- msrv32_pkg holds:
  - state encoding constants (IDLE/WR/RD/DONE/ERR, 3-bit);
  - size constants LS_BYTE=2'b00, LS_HALF=2'b01, LS_WORD=2'b10;
  - the default TIMEOUT_CYCLES value.
- One sub-module, msrv32_load_align: combinational byte/half selection and sign/zero extension, taking data, offset, size and unsigned flag.
- Store lane/mask generation stays inline.

Test Plan:
- sb, iadder=0x1003, rs2=0x000000A5, hready_in=1 immediately -> dmaddr_out=0x1000, mask=1000, dmdata_out=0xA5A5A5A5; stall_out high 2 cycles, then low.
- lh, iadder=0x2002, load_unsigned=0, dmdata_in=0x8001_1234, hready_in after 3 wait cycles -> load_data_out=0xFFFF8001; load_valid_out pulses exactly once, in DONE; stall_out high for 5 cycles.
- lbu, iadder=0x2001, dmdata_in=0x0000_F000 -> load_data_out=0x000000F0.
- sw with hready_in held low, TIMEOUT_CYCLES=16 -> dmwr_req_out high 16 cycles, then one bus_error_out pulse; stall_out drops; state returns to IDLE.
- mem_wr_req_in with trap_taken_in=1 in IDLE -> no bus request, stall_out=0. trap_taken_in asserted during RD -> transaction still completes normally.
- Reset asserted during RD -> next cycle dmrd_req_out=0, stall_out=0, load_data_out=0, and no load_valid_out pulse.

Source files
------------

// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared state encoding, access sizes and timeout default for the LSU control stage
package msrv32_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD, DONE, ERR} state_t;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
  localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/msrv32_load_align.sv
// msrv32_load_align: selects the addressed byte/half of a bus word and sign- or zero-extends it
module msrv32_load_align
  import msrv32_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = data[{offset, 3'b000} +: 8];
  assign h = data[{offset[1], 4'b0000} +: 16];
  always_comb begin
    result = size == LS_BYTE ? {{24{~unsigned_load & b[7]}}, b} :
             size == LS_HALF ? {{16{~unsigned_load & h[15]}}, h} : data;
  end
endmodule

// File: rtl/msrv32_lsu_ctrl.sv
// msrv32_lsu_ctrl: load/store bus handshake with timeout, pipeline stall and aligned load return
module msrv32_lsu_ctrl
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int CNT_W = 5
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        mem_wr_req_in,
  input  logic        mem_rd_req_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        trap_taken_in,
  input  logic        hready_in,
  input  logic [31:0] dmdata_in,
  output logic [31:0] dmaddr_out,
  output logic [31:0] dmdata_out,
  output logic [3:0]  dmwr_mask_out,
  output logic        dmwr_req_out,
  output logic        dmrd_req_out,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        bus_error_out
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0] off, size;
  logic uns, is_rd, accept, bus, timeout;
  logic [31:0] aligned;
  assign accept = state == IDLE && (mem_wr_req_in || mem_rd_req_in) && !trap_taken_in;
  assign bus = state == WR || state == RD;
  assign timeout = !hready_in && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_nxt = accept ? (mem_wr_req_in ? WR : RD) :
                bus ? (hready_in ? DONE : timeout ? ERR : state) : IDLE;
  end
  msrv32_load_align u_align (
    .data(dmdata_in),
    .offset(off),
    .size(size),
    .unsigned_load(uns),
    .result(aligned)
  );
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state <= IDLE;
      cnt <= '0;
      off <= '0;
      size <= '0;
      uns <= 1'b0;
      is_rd <= 1'b0;
      dmaddr_out <= '0;
      dmdata_out <= '0;
      dmwr_mask_out <= '0;
      load_data_out <= '0;
    end else begin
      state <= state_nxt;
      cnt <= bus && !hready_in ? cnt + CNT_W'(1) : '0;
      if (accept) begin
        off <= iadder_in[1:0];
        size <= load_size_in;
        uns <= load_unsigned_in;
        is_rd <= !mem_wr_req_in;
        dmaddr_out <= {iadder_in[31:2], 2'b00};
        dmdata_out <= load_size_in == LS_BYTE ? {4{rs2_in[7:0]}} :
                      load_size_in == LS_HALF ? {2{rs2_in[15:0]}} : rs2_in;
        dmwr_mask_out <= load_size_in == LS_BYTE ? 4'b0001 << iadder_in[1:0] :
                         load_size_in == LS_HALF ? (iadder_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      end
      if (state == RD && hready_in) load_data_out <= aligned;
    end
  end
  assign dmwr_req_out = state == WR;
  assign dmrd_req_out = state == RD;
  assign stall_out = accept || bus;
  assign load_valid_out = state == DONE && is_rd;
  assign bus_error_out = state == ERR;
endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// tb_msrv32_lsu_ctrl: randomized self-checking bench against an arithmetic model of the load/store stage
module tb_msrv32_lsu_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_wr_req = 1'b0, mem_rd_req = 1'b0, load_unsigned = 1'b0, trap_taken = 1'b0, hready = 1'b0;
  logic [1:0] load_size = 2'b00;
  logic [31:0] iadder = '0, rs2 = '0, dmdata_in = '0;
  logic [31:0] dmaddr, dmdata_o, load_data;
  logic [3:0] mask;
  logic wr_req, rd_req, stall, load_valid, bus_error;
  int checks = 0, fails = 0;
  logic [31:0] model_ld = '0;

  always #5 clk = ~clk;

  msrv32_lsu_ctrl dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .mem_wr_req_in(mem_wr_req),
    .mem_rd_req_in(mem_rd_req),
    .load_size_in(load_size),
    .load_unsigned_in(load_unsigned),
    .iadder_in(iadder),
    .rs2_in(rs2),
    .trap_taken_in(trap_taken),
    .hready_in(hready),
    .dmdata_in(dmdata_in),
    .dmaddr_out(dmaddr),
    .dmdata_out(dmdata_o),
    .dmwr_mask_out(mask),
    .dmwr_req_out(wr_req),
    .dmrd_req_out(rd_req),
    .stall_out(stall),
    .load_data_out(load_data),
    .load_valid_out(load_valid),
    .bus_error_out(bus_error)
  );

  function automatic logic [3:0] exp_mask(logic [1:0] sz, logic [1:0] off);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return off >= 2 ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [1:0] sz, logic [31:0] d);
    if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(logic [1:0] sz, bit u, logic [1:0] off, logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (d >> (8 * off)) % 256;
      if (!u && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * (off / 2))) % 65536;
      if (!u && v >= 32768) v = v - 65536;
    end else v = d;
    return v;
  endfunction

  task automatic run_access(input string name, input bit wr, input bit rd, input logic [1:0] sz, input bit u,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd_data,
                            input int waits, input bit trap_mid);
    int stalls = 0, reqs = 0, valids = 0, errs = 0, bad_bus = 0, bad_ld = 0;
    bit ok = waits < 16;
    int ncyc = (ok ? waits + 2 : 17) + 2;
    logic [31:0] exp_new = (rd && !wr && ok) ? exp_load(sz, u, addr[1:0], rd_data) : model_ld;
    @(negedge clk);
    mem_wr_req = wr; mem_rd_req = rd; load_size = sz; load_unsigned = u;
    iadder = addr; rs2 = wd; hready = 1'b0; trap_taken = 1'b0; dmdata_in = $urandom;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(negedge clk);
        mem_wr_req = 1'b0; mem_rd_req = 1'b0; trap_taken = trap_mid;
        hready = reqs == waits;
        dmdata_in = reqs == waits ? rd_data : $urandom;
      end
      #1;
      if (stall) stalls++;
      if (wr_req || rd_req) begin
        reqs++;
        if ((wr ? rd_req : wr_req) || dmaddr !== {addr[31:2], 2'b00}) bad_bus++;
        if (wr && (dmdata_o !== exp_wdata(sz, wd) || mask !== exp_mask(sz, addr[1:0]))) bad_bus++;
      end
      if (load_valid) begin
        valids++;
        if (load_data !== exp_new) bad_ld++;
      end
      if (bus_error) errs++;
    end
    trap_taken = 1'b0; hready = 1'b0;
    model_ld = exp_new;
    checks += 6;
    if (stalls != (ok ? waits + 2 : 17)) begin fails++; $display("FAIL %s stall_cycles got %0d expected %0d", name, stalls, ok ? waits + 2 : 17); end
    if (reqs != (ok ? waits + 1 : 16)) begin fails++; $display("FAIL %s req_cycles got %0d expected %0d", name, reqs, ok ? waits + 1 : 16); end
    if (valids != ((rd && !wr && ok) ? 1 : 0)) begin fails++; $display("FAIL %s load_valid_pulses got %0d expected %0d", name, valids, (rd && !wr && ok) ? 1 : 0); end
    if (errs != (ok ? 0 : 1)) begin fails++; $display("FAIL %s bus_error_pulses got %0d expected %0d", name, errs, ok ? 0 : 1); end
    if (bad_bus != 0 || bad_ld != 0) begin fails++; $display("FAIL %s bus_fields bad_bus=%0d bad_load=%0d expected 0/0", name, bad_bus, bad_ld); end
    if (load_data !== model_ld) begin fails++; $display("FAIL %s load_data got %h expected %h", name, load_data, model_ld); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({dmaddr, dmdata_o, mask, wr_req, rd_req, stall, load_data, load_valid, bus_error} !== '0) begin
      fails++;
      $display("FAIL reset outputs got addr=%h data=%h mask=%b wr=%b rd=%b stall=%b ld=%h v=%b err=%b expected all 0",
               dmaddr, dmdata_o, mask, wr_req, rd_req, stall, load_data, load_valid, bus_error);
    end
    rst = 1'b0;
    model_ld = '0;
  endtask

  task automatic test_store;
    run_access("sb_1003", 1, 0, 2'd0, 0, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0);
    run_access("sh_1006", 1, 0, 2'd1, 0, 32'h1006, 32'hDEAD_BEEF, 32'h0, 1, 0);
    run_access("sw_size11", 1, 0, 2'd3, 0, 32'h1008, 32'h1234_5678, 32'h0, 2, 0);
  endtask

  task automatic test_load;
    run_access("lh_2002", 0, 1, 2'd1, 0, 32'h2002, 32'h0, 32'h8001_1234, 3, 0);
    run_access("lbu_2001", 0, 1, 2'd0, 1, 32'h2001, 32'h0, 32'h0000_F000, 0, 0);
    run_access("lb_2001", 0, 1, 2'd0, 0, 32'h2001, 32'h0, 32'h0000_F000, 1, 0);
  endtask

  task automatic test_timeout;
    run_access("sw_timeout", 1, 0, 2'd2, 0, 32'h3000, 32'hCAFE_F00D, 32'h0, 16, 0);
    run_access("lw_timeout", 0, 1, 2'd2, 0, 32'h3004, 32'h0, 32'h5555_AAAA, 20, 0);
  endtask

  task automatic test_trap;
    @(negedge clk);
    mem_wr_req = 1'b1; trap_taken = 1'b1; iadder = 32'h4000;
    #1;
    checks++;
    if (stall !== 1'b0) begin fails++; $display("FAIL trap_idle stall got %b expected 0", stall); end
    @(negedge clk);
    mem_wr_req = 1'b0; trap_taken = 1'b0;
    #1;
    checks++;
    if (wr_req !== 1'b0 || rd_req !== 1'b0) begin fails++; $display("FAIL trap_idle req got wr=%b rd=%b expected 0/0", wr_req, rd_req); end
    run_access("lw_trap_mid", 0, 1, 2'd2, 0, 32'h4004, 32'h0, 32'h0BAD_CAFE, 2, 1);
  endtask

  task automatic test_back_to_back;
    run_access("both_req_write_wins", 1, 1, 2'd0, 0, 32'h5002, 32'h0000_003C, 32'hFFFF_FFFF, 0, 0);
    run_access("lhu_b2b", 0, 1, 2'd1, 1, 32'h5002, 32'h0, 32'h8001_1234, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      bit wr = $urandom_range(0, 1);
      int w = (i == 11) ? 17 : $urandom_range(0, 5);
      run_access($sformatf("rand_%0d", i), wr, !wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, w, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid;
    int valids = 0;
    @(negedge clk);
    mem_rd_req = 1'b1; load_size = 2'd2; iadder = 32'h6000; hready = 1'b0;
    @(negedge clk);
    mem_rd_req = 1'b0;
    #1;
    checks++;
    if (rd_req !== 1'b1) begin fails++; $display("FAIL reset_mid pre rd_req got %b expected 1", rd_req); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rd_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid post rd=%b stall=%b ld=%h expected 0/0/0", rd_req, stall, load_data);
    end
    rst = 1'b0; hready = 1'b1; dmdata_in = 32'h7777_7777;
    model_ld = '0;
    for (int c = 0; c < 4; c++) begin
      if (load_valid) valids++;
      @(negedge clk);
      #1;
    end
    hready = 1'b0;
    checks++;
    if (valids != 0) begin fails++; $display("FAIL reset_mid load_valid_pulses got %0d expected 0", valids); end
  endtask

  initial begin
    test_reset;
    test_store;
    test_load;
    test_timeout;
    test_trap;
    test_back_to_back;
    test_random;
    test_reset_mid;
    test_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
